// File: rtl/ps2_cmd_arbiter.sv
// Round-robin sharing of one PS/2 byte transmitter/receiver between two command
// requesters, with ACK/resend/error handling, bounded retries and per-state timeout.
module ps2_cmd_arbiter #(
   parameter int TIMEOUT   = 2500000,
   parameter int MAX_RETRY = 3,
   parameter int CNT_W     = 22
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ0,
   input  logic       REQ1,
   input  logic [7:0] CMD0,
   input  logic [7:0] CMD1,
   output logic       DONE0,
   output logic       DONE1,
   output logic [1:0] RESULT,
   output logic       BUSY,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   output logic       READ_ENABLE,
   input  logic       BYTE_READY,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE
);

   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [1:0] RES_ACK = 2'b00;
   localparam logic [1:0] RES_ERR = 2'b01;
   localparam logic [1:0] RES_TMO = 2'b10;

   localparam logic [7:0] DEV_ACK    = 8'hFA;
   localparam logic [7:0] DEV_RESEND = 8'hFE;
   localparam logic [7:0] DEV_ERROR  = 8'hFC;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_SENT,
      S_WAIT_ACK,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_q, last_d;
   logic [RTY_W-1:0]  retry_q, retry_d;
   logic [CNT_W-1:0]  timer_q, timer_d;
   logic [7:0]        byte_q, byte_d;
   logic [1:0]        result_q, result_d;
   logic              expired;
   logic              retry_req;
   logic              retry_err;

   assign expired = (timer_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         grant_q  <= 1'b0;
         last_q   <= 1'b1;
         retry_q  <= '0;
         timer_q  <= '0;
         byte_q   <= 8'h00;
         result_q <= RES_ACK;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         retry_q  <= retry_d;
         timer_q  <= timer_d;
         byte_q   <= byte_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      retry_d   = retry_q;
      timer_d   = timer_q;
      byte_d    = byte_q;
      result_d  = result_q;
      retry_req = 1'b0;
      retry_err = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (REQ0 || REQ1) begin
               // Contention goes to whichever requester was not served last.
               grant_d = (REQ0 && REQ1) ? ~last_q : REQ1;
               byte_d  = grant_d ? CMD1 : CMD0;
               retry_d = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            timer_d = '0;
            state_d = S_WAIT_SENT;
         end
         S_WAIT_SENT: begin
            timer_d = timer_q + CNT_W'(1);
            if (BYTE_SENT) begin
               timer_d = '0;
               state_d = S_WAIT_ACK;
            end else if (expired) begin
               retry_req = 1'b1;
            end
         end
         S_WAIT_ACK: begin
            timer_d = timer_q + CNT_W'(1);
            // A decisive reply outranks a simultaneous timeout; unrecognised bytes do not.
            if (BYTE_READY && (BYTE_ERROR_CODE != 2'b00 || BYTE_READ == DEV_RESEND)) begin
               retry_req = 1'b1;
               retry_err = 1'b1;
            end else if (BYTE_READY && BYTE_READ == DEV_ACK) begin
               result_d = RES_ACK;
               state_d  = S_DONE;
            end else if (BYTE_READY && BYTE_READ == DEV_ERROR) begin
               result_d = RES_ERR;
               state_d  = S_DONE;
            end else if (expired) begin
               retry_req = 1'b1;
            end
         end
         S_DONE: begin
            last_d  = grant_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (retry_req) begin
         if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_SEND;
         end else begin
            result_d = retry_err ? RES_ERR : RES_TMO;
            state_d  = S_DONE;
         end
      end
   end

   assign SEND_BYTE    = (state_q == S_SEND);
   assign READ_ENABLE  = (state_q == S_WAIT_ACK);
   assign BUSY         = (state_q != S_IDLE);
   assign DONE0        = (state_q == S_DONE) && !grant_q;
   assign DONE1        = (state_q == S_DONE) && grant_q;
   assign RESULT       = result_q;
   assign BYTE_TO_SEND = byte_q;

endmodule
